// File: rtl/contador_pkg.sv
// Shared constants for the run/pause/direction counter controller.
package contador_pkg;

    localparam int unsigned COUNT_W = 6;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

endpackage

// File: rtl/contador_ctrl_btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, optional debouncer, registered rising-edge pulse.
// The debouncer is built only when CONTADOR_DEBOUNCE_EN is defined.
module btn_cond #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    logic sync1_q, sync2_q;
    logic level;
    logic level_q;
    logic press_q;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("btn_cond: DEB_CYCLES must be >= 1");
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef CONTADOR_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             stable_q, stable_d;

    // The counter runs only while the synchronized level disagrees with the accepted one.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt_q <= '0;
            stable_q  <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            stable_q  <= stable_d;
        end
    end

    assign level = stable_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            level_q <= level;
            press_q <= level & ~level_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/contador_ctrl.sv
// Run/pause/direction controller stepping a 0..MAX_COUNT count once per TICK_DIV cycles.
// Button debouncing is enabled by defining CONTADOR_DEBOUNCE_EN.
module contador_ctrl
    import contador_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned MAX_COUNT  = 63,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               btn_start,
    input  logic               btn_dir,
    input  logic               btn_clear,
    output logic [COUNT_W-1:0] count,
    output logic               dir_up,
    output logic               running,
    output logic               tick,
    output logic               wrap,
    output logic [1:0]         state_dbg
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(MAX_COUNT);

    if (TICK_DIV < 2 || MAX_COUNT > 63) begin : g_bad_param
        $error("contador_ctrl: TICK_DIV must be >= 2 and MAX_COUNT <= 63");
    end

    logic start_press, dir_press, clear_press;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
        .clock(clock), .reset_n(reset_n), .btn(btn_start), .press(start_press));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_dir (
        .clock(clock), .reset_n(reset_n), .btn(btn_dir), .press(dir_press));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clear (
        .clock(clock), .reset_n(reset_n), .btn(btn_clear), .press(clear_press));

    logic [1:0]         state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               dir_q, dir_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;
    logic               step;

    assign step = (state_q == ST_RUN) && (div_cnt_q == DIV_LAST);

    // Clear overrides everything else; the step always uses the pre-toggle direction.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        count_d   = count_q;
        dir_d     = dir_press ? ~dir_q : dir_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        if (clear_press) begin
            state_d   = ST_IDLE;
            div_cnt_d = '0;
            count_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    div_cnt_d = '0;
                    count_d   = '0;
                    if (start_press) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (start_press) state_d = ST_PAUSE;
                    div_cnt_d = step ? '0 : div_cnt_q + DIV_W'(1);
                    if (step) begin
                        tick_d = 1'b1;
                        if (dir_q) begin
                            wrap_d  = (count_q == CNT_MAX);
                            count_d = wrap_d ? '0 : count_q + COUNT_W'(1);
                        end else begin
                            wrap_d  = (count_q == '0);
                            count_d = wrap_d ? CNT_MAX : count_q - COUNT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    div_cnt_d = '0;
                    if (start_press) state_d = ST_RUN;
                end
                default: begin
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                    count_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            count_q   <= '0;
            dir_q     <= 1'b1;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign count     = count_q;
    assign dir_up    = dir_q;
    assign running   = (state_q == ST_RUN);
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed bench for contador_ctrl with TICK_DIV=4, MAX_COUNT=63, debounce off.
module tb_contador_ctrl;

    logic       clock;
    logic       reset_n;
    logic       btn_start, btn_dir, btn_clear;
    logic [5:0] count;
    logic       dir_up, running, tick, wrap;
    logic [1:0] state_dbg;

    int n_total = 0;
    int n_bad   = 0;

    contador_ctrl #(
        .TICK_DIV  (4),
        .MAX_COUNT (63),
        .DEB_CYCLES(8)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_start(btn_start),
        .btn_dir  (btn_dir),
        .btn_clear(btn_clear),
        .count    (count),
        .dir_up   (dir_up),
        .running  (running),
        .tick     (tick),
        .wrap     (wrap),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Button rise at a negedge: press lands 3 edges later, state after the 4th edge.
    task automatic pulse_btn(input int which);
        case (which)
            0: btn_start = 1'b1;
            1: btn_dir   = 1'b1;
            default: btn_clear = 1'b1;
        endcase
        repeat (4) @(posedge clock);
        @(negedge clock);
        btn_start = 1'b0;
        btn_dir   = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic wait_count(input int value, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (count != 6'(value) && n < budget);
        check_eq(tag, int'(count), value);
    endtask

    task automatic expect_step(input int value, input int wr, input string tag);
        repeat (3) begin
            @(negedge clock);
            check_eq({tag, "_tick_lo"}, int'(tick), 0);
        end
        @(negedge clock);
        check_eq({tag, "_tick"}, int'(tick), 1);
        check_eq({tag, "_count"}, int'(count), value);
        check_eq({tag, "_wrap"}, int'(wrap), wr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rises;
        logic prev_run;

        reset_n   = 1'b0;
        btn_start = 1'b0;
        btn_dir   = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_count",   int'(count),     0);
        check_eq("rst_dir",     int'(dir_up),    1);
        check_eq("rst_running", int'(running),   0);
        check_eq("rst_tick",    int'(tick),      0);
        check_eq("rst_wrap",    int'(wrap),      0);
        check_eq("rst_state",   int'(state_dbg), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // start and count 0 -> 1 -> 2 -> 3
        pulse_btn(0);
        check_eq("start_running", int'(running), 1);
        check_eq("start_count",   int'(count),   0);
        expect_step(1, 0, "s1");
        expect_step(2, 0, "s2");
        expect_step(3, 0, "s3");

        // ascending wrap 63 -> 0
        wait_count(63, 400, "reach63");
        expect_step(0, 1, "wrap_up");
        @(negedge clock);
        check_eq("wrap_up_tick_end", int'(tick), 0);
        check_eq("wrap_up_wrap_end", int'(wrap), 0);

        // dir press in IDLE, then descending from 0
        pulse_btn(2);
        check_eq("clear_running", int'(running), 0);
        check_eq("clear_count",   int'(count),   0);
        pulse_btn(1);
        check_eq("idle_dir", int'(dir_up),  0);
        check_eq("idle_run", int'(running), 0);
        pulse_btn(0);
        check_eq("down_running", int'(running), 1);
        expect_step(63, 1, "down63");
        expect_step(62, 0, "down62");

        // pause at 10, hold, resume to 11
        pulse_btn(2);
        pulse_btn(1);
        check_eq("dir_back_up", int'(dir_up), 1);
        pulse_btn(0);
        wait_count(9, 200, "reach9");
        @(negedge clock);
        pulse_btn(0);
        check_eq("pause_running", int'(running),   0);
        check_eq("pause_state",   int'(state_dbg), 2);
        check_eq("pause_count",   int'(count),     10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_eq("pause_hold_tick",  int'(tick),  0);
            check_eq("pause_hold_count", int'(count), 10);
        end
        pulse_btn(0);
        check_eq("resume_running", int'(running), 1);
        expect_step(11, 0, "resume");

        // clear collides with a due step at count 5
        pulse_btn(2);
        pulse_btn(0);
        wait_count(5, 200, "reach5");
        pulse_btn(2);
        check_eq("clr_step_state", int'(state_dbg), 0);
        check_eq("clr_step_count", int'(count),     0);
        check_eq("clr_step_tick",  int'(tick),      0);
        check_eq("clr_step_run",   int'(running),   0);

        // asynchronous reset mid-run, then a held start button
        pulse_btn(1);
        pulse_btn(0);
        wait_count(30, 400, "reach30");
        check_eq("pre_rst_dir", int'(dir_up), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_count",   int'(count),   0);
        check_eq("async_dir",     int'(dir_up),  1);
        check_eq("async_running", int'(running), 0);
        check_eq("async_tick",    int'(tick),    0);
        btn_start = 1'b1;
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        rises    = 0;
        prev_run = running;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (running && !prev_run) rises++;
            prev_run = running;
        end
        check_eq("held_start_rises",   rises,         1);
        check_eq("held_start_running", int'(running), 1);
        check_eq("held_start_dir",     int'(dir_up),  1);
        btn_start = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
